// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and sizing helpers for the sequential divider
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // All-ones quotient reported on divide-by-zero, right-aligned to dw bits
  function automatic logic [63:0] dbz_quot(input int dw);
    return {64{1'b1}} >> (64 - dw);
  endfunction

  function automatic int cnt_w(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

endpackage

// File: rtl/div_seq_param_if.sv
// rtl/div_seq_param_if.sv - operand/result valid-ready bundle for div_seq_param
interface div_seq_param_if #(
  parameter int DW = 16,
  parameter int VW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dbz;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz
  );
endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] i_pr,
  input  logic          i_bit,
  input  logic [VW-1:0] i_div,
  output logic [VW-1:0] o_pr,
  output logic          o_qbit
);
  // The VW+1-bit shifted remainder only needs its top bit for the compare;
  // a successful subtraction always leaves a value below the divisor.
  logic [VW:0]   w_sh;
  logic [VW-1:0] w_diff;
  logic          w_ge;

  assign w_sh   = {i_pr, i_bit};
  assign w_ge   = (w_sh >= {1'b0, i_div});
  assign w_diff = w_sh[VW-1:0] - i_div;
  assign o_pr   = w_ge ? w_diff : w_sh[VW-1:0];
  assign o_qbit = w_ge;
endmodule

// File: rtl/div_seq_param.sv
// rtl/div_seq_param.sv - multi-cycle restoring divider, one quotient bit per clock
// Optional signed operation selected by DIV_SIGNED_EN.
module div_seq_param
  import div_pkg::*;
#(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic             clk,
  input  logic             rst,
  div_seq_param_if.slave   bus
);
  localparam int            CW        = cnt_w(DW);
  localparam logic [63:0]   DBZ_Q_ALL = dbz_quot(DW);
  localparam logic [CW-1:0] CNT_LOAD  = CW'(DW - 1);

  div_state_e    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_dq, r_q;
  logic [VW-1:0] r_pr, r_dvs, r_rem;
  logic          r_dbz;

  logic          w_accept, w_dbz_in, w_qbit;
  logic [VW-1:0] w_pr_nxt;
  logic [DW-1:0] w_dq_nxt, w_dd_mag;
  logic [VW-1:0] w_dv_mag;

`ifdef DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;
  // Magnitudes of the most-negative values read back correctly as unsigned
  assign w_dd_mag = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
  assign w_dv_mag = bus.divisor[VW-1]  ? -bus.divisor  : bus.divisor;
`else
  assign w_dd_mag = bus.dividend;
  assign w_dv_mag = bus.divisor;
`endif

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_dbz_in = (bus.divisor == '0);
  assign w_dq_nxt = {r_dq[DW-2:0], w_qbit};

  div_step #(.VW(VW)) u_step (
    .i_pr  (r_pr),
    .i_bit (r_dq[DW-1]),
    .i_div (r_dvs),
    .o_pr  (w_pr_nxt),
    .o_qbit(w_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_dbz_in ? DONE : CALC;
      CALC: if (r_cnt == '0) begin
`ifdef DIV_SIGNED_EN
        w_state_nxt = FIX;
`else
        w_state_nxt = DONE;
`endif
      end
`ifdef DIV_SIGNED_EN
      FIX:  w_state_nxt = DONE;
`endif
      DONE: if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.quotient  = r_q;
  assign bus.remainder = r_rem;
  assign bus.dbz       = r_dbz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_dq  <= '0;
      r_pr  <= '0;
      r_dvs <= '0;
      r_q   <= '0;
      r_rem <= '0;
      r_dbz <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_dbz_in) begin
            r_q   <= DBZ_Q_ALL[DW-1:0];
            r_rem <= '0;
            r_dbz <= 1'b1;
          end else begin
            r_dq  <= w_dd_mag;
            r_dvs <= w_dv_mag;
            r_pr  <= '0;
            r_cnt <= CNT_LOAD;
`ifdef DIV_SIGNED_EN
            r_neg_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
            r_neg_r <= bus.dividend[DW-1];
`endif
          end
        end
        CALC: begin
          r_dq <= w_dq_nxt;
          r_pr <= w_pr_nxt;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
`ifndef DIV_SIGNED_EN
            r_q   <= w_dq_nxt;
            r_rem <= w_pr_nxt;
            r_dbz <= 1'b0;
`endif
          end
        end
`ifdef DIV_SIGNED_EN
        FIX: begin
          r_q   <= r_neg_q ? -r_dq : r_dq;
          r_rem <= r_neg_r ? -r_pr : r_pr;
          r_dbz <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: doc/div_seq_param.md
# div_seq_param

Parametrised multi-cycle restoring divider: a DW-bit dividend by a VW-bit divisor, producing a DW-bit quotient and a VW-bit remainder, one quotient bit per clock. It is the sequential successor of the team's fixed 16/8 combinational divider. It sits in the arithmetic datapath behind a valid/ready input and a valid/ready output, so it can be placed between pipeline stages with backpressure. Division by zero is detected explicitly and flagged. Signed operation is a compile-time option.

## Interface
- DW, 16, dividend and quotient width; legal range 2..64.
- VW, 8, divisor and remainder width; legal range 1..DW.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands.
- dividend  in  DW  dividend, sampled at acceptance.
- divisor  in  VW  divisor, sampled at acceptance.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- quotient  out  DW  quotient.
- remainder  out  VW  remainder.
- dbz  out  1  divide-by-zero flag, qualified by out_valid.

## Operation
- FSM states are IDLE, CALC, FIX and DONE. FIX exists only when DIV_SIGNED_EN is defined.
- IDLE: in_ready=1.
  - Acceptance occurs on the edge where in_valid && in_ready.
  - If divisor==0, go to DONE with quotient all-ones, remainder 0 and dbz=1.
  - Otherwise latch the operands, clear the partial remainder (VW+1 bits), load cnt=DW-1 and go to CALC.
- CALC: each edge performs one restoring step.
  - pr = {pr[VW-1:0], dq[DW-1]}; dq shifts left.
  - If pr >= {1'b0, divisor}: pr = pr - divisor and the new dq LSB = 1; otherwise the LSB = 0.
  - When cnt==0, go to DONE (unsigned) or FIX (signed). Otherwise decrement cnt.
- DONE: out_valid=1 and in_ready=0. quotient=dq, remainder=pr[VW-1:0], dbz=0 (or 1 for the divide-by-zero path).
  - Outputs hold stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - No new operands are accepted in the same cycle as a handoff.
- Outputs outside DONE hold their last values. Only out_valid qualifies them.
- The operand registers isolate the block: dividend and divisor may change freely after acceptance.

## Timing
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, dbz=0, FSM=IDLE, cnt=0.
- Latency, unsigned: out_valid rises DW clocks after the acceptance edge.
- Latency, signed: out_valid rises DW+1 clocks after the acceptance edge.
- Latency, divide-by-zero: out_valid rises 1 clock after acceptance, in either mode.
- Maximum throughput is one operation per DW+2 clocks (unsigned) with out_ready held high.
- in_ready is a pure function of the FSM state. It does not depend combinationally on in_valid or out_ready.
- Reset asserted mid-operation aborts immediately: the in-flight result is discarded and no out_valid is produced. The first acceptance is possible on the first edge after rst deasserts.
- cnt width is $clog2(DW). cnt never wraps: the CALC exit is on cnt==0.

## Configuration
- DIV_SIGNED_EN defined:
  - Both operands are two's complement. Magnitudes are taken at acceptance and an extra FIX cycle applies signs.
  - The quotient is truncated toward zero and negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Most-negative dividend divided by -1 wraps: quotient = 1 followed by DW-1 zeros, remainder 0, dbz=0.
  - The divide-by-zero result is unchanged from unsigned mode.
- DIV_SIGNED_EN undefined: operands are unsigned, the FIX state and its logic are absent, and latency is DW.

## Structure
- Package div_pkg holds:
  - the FSM state enum (IDLE, CALC, FIX, DONE);
  - the divide-by-zero quotient constant, all-ones, as a function of DW;
  - the localparam helper computing the cnt width.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: pr, the incoming dividend bit, divisor.
  - Outputs: next pr, quotient bit.
  - The top level instantiates it once and reuses it every CALC cycle.

## Test plan
- Unsigned, DW=16/VW=8: dividend=1000, divisor=7 -> quotient=142, remainder=6, dbz=0; out_valid exactly 16 clocks after acceptance.
- Unsigned: dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0. Also dividend=5, divisor=9 -> quotient=0, remainder=5.
- Divide-by-zero: dividend=0x1234, divisor=0 -> quotient=0xFFFF, remainder=0, dbz=1; out_valid 1 clock after acceptance.
- Backpressure: out_ready held low for 5 clocks in DONE -> quotient/remainder/dbz stable, in_ready=0 throughout; IDLE is re-entered on the edge after out_ready=1.
- Reset at the 4th CALC clock -> out_valid stays 0 and in_ready=1 immediately. A following 1000/7 yields 142 r 6.
- DIV_SIGNED_EN, DW=16/VW=8:
  - 0xFC18 (-1000) / 7 -> quotient=0xFF72, remainder=0xFA.
  - 1000 / 0xF9 (-7) -> quotient=0xFF72, remainder=6.
  - 0x8000 / 0xFF -> quotient=0x8000, remainder=0.
  - Latency is 17 clocks.
